// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - byte-stream boot loader bus initiator; optional readback verify via LOADER_VERIFY_EN
module mem_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] wordCount,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic [15:0] addrBus,
  inout  wire  [15:0] dataBus,
  output logic        writeMEM,
  output logic        readMEM,
  input  logic        readyMem,
  output logic        cpuRst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // Last wait-counter value before a bus cycle is abandoned.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_HI,
    GET_LO,
    WRITE,
`ifdef LOADER_VERIFY_EN
    RD,
    CMP,
`endif
    FINISH
  } stateT;

  stateT       state, stateNext;
  logic [15:0] idx, idxNext;
  logic [15:0] count, countNext;
  logic [15:0] word, wordNext;
  logic [15:0] tmoCnt, tmoNext;
  logic [15:0] addrNext;
  logic        errorNext;
  logic        cpuRstNext;
  logic        lastWord;

`ifdef LOADER_VERIFY_EN
  logic [15:0] rdData, rdDataNext;
`endif

  // The word just finished is the last one when idx+1 reaches the latched count.
  assign lastWord = ({1'b0, idx} + 17'd1) >= {1'b0, count};

  // Write data is only put on the shared bus while our write request is up.
  assign dataBus = writeMEM ? word : 16'hzzzz;

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    countNext  = count;
    wordNext   = word;
    tmoNext    = tmoCnt;
    addrNext   = addrBus;
    errorNext  = error;
    cpuRstNext = cpuRst;
`ifdef LOADER_VERIFY_EN
    rdDataNext = rdData;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          countNext  = wordCount;
          idxNext    = 16'd0;
          errorNext  = 1'b0;
          cpuRstNext = 1'b1;
          stateNext  = (wordCount == 16'd0) ? FINISH : GET_HI;
        end
      end
      GET_HI: begin
        if (inValid && inReady) begin
          wordNext[15:8] = inData;
          stateNext      = GET_LO;
        end
      end
      GET_LO: begin
        if (inValid && inReady) begin
          wordNext[7:0] = inData;
          addrNext      = BASE_ADDR + idx;
          tmoNext       = 16'd0;
          stateNext     = WRITE;
        end
      end
      WRITE: begin
        if (readyMem) begin
`ifdef LOADER_VERIFY_EN
          tmoNext   = 16'd0;
          stateNext = RD;
`else
          idxNext   = idx + 16'd1;
          stateNext = lastWord ? FINISH : GET_HI;
`endif
        end else if (tmoCnt == TMO_LAST) begin
          errorNext = 1'b1;
          stateNext = FINISH;
        end else begin
          tmoNext = tmoCnt + 16'd1;
        end
      end
`ifdef LOADER_VERIFY_EN
      RD: begin
        if (readyMem) begin
          rdDataNext = dataBus;
          stateNext  = CMP;
        end else if (tmoCnt == TMO_LAST) begin
          errorNext = 1'b1;
          stateNext = FINISH;
        end else begin
          tmoNext = tmoCnt + 16'd1;
        end
      end
      CMP: begin
        if (rdData != word) begin
          errorNext = 1'b1;
          stateNext = FINISH;
        end else begin
          idxNext   = idx + 16'd1;
          stateNext = lastWord ? FINISH : GET_HI;
        end
      end
`endif
      FINISH: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // The processor is let go at the end of every load, even a failed one.
    if (stateNext == FINISH) cpuRstNext = 1'b0;
  end

  // State, datapath and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 16'd0;
      count    <= 16'd0;
      word     <= 16'd0;
      tmoCnt   <= 16'd0;
      addrBus  <= 16'h0000;
      error    <= 1'b0;
      cpuRst   <= 1'b1;
      inReady  <= 1'b0;
      writeMEM <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      idx      <= idxNext;
      count    <= countNext;
      word     <= wordNext;
      tmoCnt   <= tmoNext;
      addrBus  <= addrNext;
      error    <= errorNext;
      cpuRst   <= cpuRstNext;
      inReady  <= (stateNext == GET_HI) || (stateNext == GET_LO);
      writeMEM <= (stateNext == WRITE);
      busy     <= (stateNext != IDLE) && (stateNext != FINISH);
      done     <= (stateNext == FINISH);
    end
  end

`ifdef LOADER_VERIFY_EN
  // Readback request and captured readback word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readMEM <= 1'b0;
      rdData  <= 16'd0;
    end else begin
      readMEM <= (stateNext == RD);
      rdData  <= rdDataNext;
    end
  end
`else
  assign readMEM = 1'b0;
`endif

endmodule

// File: tb/tb_mem_boot_loader.sv
// tb/tb_mem_boot_loader.sv - scoreboard bench for mem_boot_loader
`timescale 1ns/1ps
module tb_mem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        inValid = 1'b0;
  logic        readyMem = 1'b1;
  logic [15:0] wordCount = 16'd0;
  logic [7:0]  inData = 8'd0;

  logic        inReadyA, writeA, readA, cpuRstA, busyA, doneA, errorA;
  logic [15:0] addrA;
  wire  [15:0] dataA;
  logic        inReadyB, writeB, readB, cpuRstB, busyB, doneB, errorB;
  logic [15:0] addrB;
  wire  [15:0] dataB;

  int checks = 0;
  int failures = 0;
  int doneCnt = 0;

  logic [15:0] memA [0:65535];
  logic [15:0] memB [0:65535];
  logic [31:0] expWrA[$];
  logic [31:0] expWrB[$];
  logic        expDoneErr[$];
  logic        prevDone = 1'b0;
  logic        corrupt = 1'b0;
  logic        rdSeen = 1'b0;

  mem_boot_loader #(.BASE_ADDR(16'h0000), .TIMEOUT(4)) dutA (
    .clk(clk), .rst(rst), .start(start), .wordCount(wordCount),
    .inData(inData), .inValid(inValid), .inReady(inReadyA),
    .addrBus(addrA), .dataBus(dataA), .writeMEM(writeA), .readMEM(readA),
    .readyMem(readyMem), .cpuRst(cpuRstA), .busy(busyA), .done(doneA), .error(errorA)
  );

  mem_boot_loader #(.BASE_ADDR(16'hFFFF), .TIMEOUT(4)) dutB (
    .clk(clk), .rst(rst), .start(start), .wordCount(wordCount),
    .inData(inData), .inValid(inValid), .inReady(inReadyB),
    .addrBus(addrB), .dataBus(dataB), .writeMEM(writeB), .readMEM(readB),
    .readyMem(readyMem), .cpuRst(cpuRstB), .busy(busyB), .done(doneB), .error(errorB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (writeA && readyMem) memA[addrA] <= dataA;
    if (writeB && readyMem) memB[addrB] <= dataB;
  end

`ifdef LOADER_VERIFY_EN
  assign dataA = readA ? (corrupt ? 16'h1235 : memA[addrA]) : 16'hzzzz;
  assign dataB = readB ? (corrupt ? 16'h1235 : memB[addrB]) : 16'hzzzz;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: completed writes and done pulses are checked against the queues.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (readA) rdSeen = 1'b1;
        if (writeA && readyMem) begin
          chk("write_a_expected", expWrA.size() != 0, 1);
          if (expWrA.size() != 0) begin
            e = expWrA.pop_front();
            chk("write_a_addr", addrA, e[31:16]);
            chk("write_a_data", dataA, e[15:0]);
          end
        end
        if (writeB && readyMem) begin
          chk("write_b_expected", expWrB.size() != 0, 1);
          if (expWrB.size() != 0) begin
            e = expWrB.pop_front();
            chk("write_b_addr", addrB, e[31:16]);
            chk("write_b_data", dataB, e[15:0]);
          end
        end
        if (doneA) begin
          doneCnt++;
          chk("done_single_cycle", prevDone, 0);
          chk("done_expected", expDoneErr.size() != 0, 1);
          if (expDoneErr.size() != 0) begin
            e = {31'd0, expDoneErr.pop_front()};
            chk("done_error", errorA, e);
            chk("done_cpuRst", cpuRstA, 0);
            chk("done_busy", busyA, 0);
          end
        end
      end
      prevDone = doneA;
    end
  end

  task automatic startLoad(input logic [15:0] n);
    start = 1'b1;
    wordCount = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    inData = b;
    inValid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = inReadyA;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    chk("byte_accepted", acc, 1);
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 100 && doneCnt < target; i++) @(posedge clk);
    #1;
    chk("done_reached", doneCnt >= target, 1);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_inReady"}, inReadyA, 0);
    chk({tag, "_writeMEM"}, writeA, 0);
    chk({tag, "_readMEM"}, readA, 0);
    chk({tag, "_busy"}, busyA, 0);
    chk({tag, "_done"}, doneA, 0);
    chk({tag, "_error"}, errorA, 0);
    chk({tag, "_cpuRst"}, cpuRstA, 1);
    chk({tag, "_addrBus"}, addrA, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    rst = 1'b0;

    // Two-word load, memory always ready; instance B wraps FFFF -> 0000.
    expWrA.push_back({16'h0000, 16'h1234});
    expWrA.push_back({16'h0001, 16'hABCD});
    expWrB.push_back({16'hFFFF, 16'h1234});
    expWrB.push_back({16'h0000, 16'hABCD});
    expDoneErr.push_back(1'b0);
    startLoad(16'd2);
    chk("load_busy", busyA, 1);
    chk("load_cpuRst_held", cpuRstA, 1);
    sendByte(8'h12);
    sendByte(8'h34);
    sendByte(8'hAB);
    sendByte(8'hCD);
    waitDone(1);
    chk("memA_0", memA[0], 16'h1234);
    chk("memA_1", memA[1], 16'hABCD);
    chk("memB_FFFF", memB[16'hFFFF], 16'h1234);
    chk("memB_0000", memB[0], 16'hABCD);
    chk("load_cpuRst_released", cpuRstA, 0);
    chk("load_error", errorA, 0);

    // Zero-word load: immediate finish, no bus cycle.
    expDoneErr.push_back(1'b0);
    startLoad(16'd0);
    chk("zero_done", doneA, 1);
    chk("zero_writeMEM", writeA, 0);
    waitDone(2);
    chk("zero_cpuRst", cpuRstA, 0);

    // Memory never ready: write held for TIMEOUT cycles then abandoned.
    readyMem = 1'b0;
    expDoneErr.push_back(1'b1);
    startLoad(16'd1);
    sendByte(8'h9A);
    sendByte(8'hBC);
    n = 0;
    for (int i = 0; i < 20 && writeA; i++) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_write_cycles", n, 4);
    chk("timeout_error", errorA, 1);
    chk("timeout_done", doneA, 1);
    waitDone(3);
    chk("timeout_writeMEM_low", writeA, 0);
    chk("timeout_mem_kept", memA[0], 16'h1234);

    // Gapped byte stream, then reset while the write is pending.
    startLoad(16'd1);
    chk("start_clears_error", errorA, 0);
    inData = 8'h56; inValid = 1'b1;
    @(posedge clk); #1;
    inData = 8'hFF; inValid = 1'b0;
    @(posedge clk); #1;
    chk("gap_inReady", inReadyA, 1);
    chk("gap_writeMEM", writeA, 0);
    inData = 8'h78; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    chk("gap_writeMEM_up", writeA, 1);
    chk("gap_word", dataA, 16'h5678);
    chk("gap_addr", addrA, 16'h0000);
    rst = 1'b1;
    #1;
    checkReset("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    readyMem = 1'b1;

    // Recovery load after reset starts again at index 0.
    expWrA.push_back({16'h0000, 16'hBEEF});
    expWrB.push_back({16'hFFFF, 16'hBEEF});
    expDoneErr.push_back(1'b0);
    startLoad(16'd1);
    sendByte(8'hBE);
    sendByte(8'hEF);
    waitDone(4);
    chk("recover_mem0", memA[0], 16'hBEEF);
    chk("recover_error", errorA, 0);

`ifdef LOADER_VERIFY_EN
    // Readback returns a corrupted word: abort after word 0.
    corrupt = 1'b1;
    rdSeen = 1'b0;
    expWrA.push_back({16'h0000, 16'h1234});
    expWrB.push_back({16'hFFFF, 16'h1234});
    expDoneErr.push_back(1'b1);
    startLoad(16'd2);
    sendByte(8'h12);
    sendByte(8'h34);
    waitDone(5);
    chk("verify_read_seen", rdSeen, 1);
    chk("verify_error", errorA, 1);
    chk("verify_busy", busyA, 0);
    corrupt = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("queues_drained", expWrA.size() + expWrB.size() + expDoneErr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
